// File: rtl/alu_defs_pkg.sv
// -----------------------------------------------------------------------------
// alu_defs
// Shared definitions for the ALU sequencing front-end: default datapath width,
// ALU opcode constants and the controller state encoding.
// -----------------------------------------------------------------------------
package alu_defs;

    // Datapath width; must match the width of the combinational ALU.
    localparam int N_DEFAULT = 3;

    // ALU opcodes, as understood by the ALU `select` input.
    localparam logic [3:0] OP_SUMA      = 4'd0;
    localparam logic [3:0] OP_RESTA     = 4'd1;
    localparam logic [3:0] OP_INC       = 4'd2;
    localparam logic [3:0] OP_DEC       = 4'd3;
    localparam logic [3:0] OP_AND       = 4'd4;
    localparam logic [3:0] OP_OR        = 4'd5;
    localparam logic [3:0] OP_NOT       = 4'd6;
    localparam logic [3:0] OP_XOR       = 4'd7;
    localparam logic [3:0] OP_SHL       = 4'd8;
    localparam logic [3:0] OP_SHR       = 4'd9;
    localparam logic [3:0] OP_MAX_VALID = 4'd9;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // True for opcodes the ALU implements.
    function automatic logic op_is_valid(input logic [3:0] sel);
        return (sel <= OP_MAX_VALID);
    endfunction

endpackage

// File: rtl/alu_flag_norm.sv
// -----------------------------------------------------------------------------
// alu_flag_norm
// Combinational flag normalisation. The ALU only drives meaningful flags for
// some opcodes; this block turns the raw flags into a consistent set per opcode.
//
// Ports:
//   select_i  opcode that produced res_i
//   res_i     ALU result
//   neg_i, zero_i, cout_i, ovf_i   raw ALU flags
//   neg_o, zero_o, cout_o, ovf_o   normalised flags
// -----------------------------------------------------------------------------
module alu_flag_norm
    import alu_defs::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [3:0]   select_i,
    input  logic [N-1:0] res_i,
    input  logic         neg_i,
    input  logic         zero_i,
    input  logic         cout_i,
    input  logic         ovf_i,
    output logic         neg_o,
    output logic         zero_o,
    output logic         cout_o,
    output logic         ovf_o
);

    // The ALU's own overflow output is never trusted: for add/inc the carry
    // doubles as the overflow indication, everywhere else overflow is forced 0.
    logic unused_ovf;
    assign unused_ovf = ovf_i;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        neg_o  = 1'b0;
        zero_o = (res_i == '0);
        cout_o = 1'b0;
        ovf_o  = 1'b0;

        case (select_i)
            OP_SUMA, OP_INC: begin
                zero_o = zero_i;
                cout_o = cout_i;
                ovf_o  = cout_i;
            end
            OP_RESTA, OP_DEC: begin
                // The ALU leaves cout/ovf undriven here; keep them at 0.
                neg_o  = neg_i;
                zero_o = zero_i;
            end
            default: begin
                // Logic and shift ops: zero computed locally from the result.
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Sequencing front-end for the combinational ALU. Accepts one request at a
// time, drives registered operands/opcode into the ALU, captures the result
// one cycle later with normalised flags, and returns it over a valid/ready
// handshake. An accumulator keeps the last good result for chaining.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_sel, in_a, in_b            opcode and operands
//   in_flag                       forwarded to ALU flagin
//   in_acc                        use accumulator in place of in_a
//   alu_a, alu_b, alu_flagin,
//   alu_select                    registered ALU inputs
//   alu_res, alu_neg, alu_zero,
//   alu_cout, alu_ovf             ALU outputs
//   out_valid/out_ready           response handshake
//   out_result, out_neg, out_zero,
//   out_cout, out_ovf, out_err    response payload
//   acc                           accumulator value
// -----------------------------------------------------------------------------
module alu_control
    import alu_defs::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_sel,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_flag,
    input  logic         in_acc,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_flagin,
    output logic [3:0]   alu_select,
    input  logic [N-1:0] alu_res,
    input  logic         alu_neg,
    input  logic         alu_zero,
    input  logic         alu_cout,
    input  logic         alu_ovf,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_neg,
    output logic         out_zero,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_err,

    output logic [N-1:0] acc
);

    state_t       state_q;
    logic [N-1:0] alu_a_q, alu_b_q;
    logic         flagin_q;
    logic [3:0]   select_q;
    logic         out_valid_q;
    logic [N-1:0] result_q, acc_q;
    logic         neg_q, zero_q, cout_q, ovf_q, err_q;

    logic [N-1:0] opa_d;
    logic         neg_d, zero_d, cout_d, ovf_d;

    // Operand A is taken from the accumulator as it stands at the accept edge.
    assign opa_d = in_acc ? acc_q : in_a;

    // Flags are normalised against the opcode currently presented to the ALU.
    alu_flag_norm #(.N(N)) u_flag_norm (
        .select_i (select_q),
        .res_i    (alu_res),
        .neg_i    (alu_neg),
        .zero_i   (alu_zero),
        .cout_i   (alu_cout),
        .ovf_i    (alu_ovf),
        .neg_o    (neg_d),
        .zero_o   (zero_d),
        .cout_o   (cout_d),
        .ovf_o    (ovf_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            flagin_q    <= 1'b0;
            select_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op_is_valid(in_sel)) begin
                            alu_a_q  <= opa_d;
                            alu_b_q  <= in_b;
                            flagin_q <= in_flag;
                            select_q <= in_sel;
                            state_q  <= ST_ISSUE;
                        end else begin
                            // Unsupported opcode: answer immediately with an
                            // error, without touching the ALU or accumulator.
                            result_q    <= '0;
                            neg_q       <= 1'b0;
                            zero_q      <= 1'b0;
                            cout_q      <= 1'b0;
                            ovf_q       <= 1'b0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                end
                ST_ISSUE: begin
                    result_q    <= alu_res;
                    acc_q       <= alu_res;
                    neg_q       <= neg_d;
                    zero_q      <= zero_d;
                    cout_q      <= cout_d;
                    ovf_q       <= ovf_d;
                    err_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_flagin = flagin_q;
    assign alu_select = select_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_neg    = neg_q;
    assign out_zero   = zero_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign out_err    = err_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_control.sv
// -----------------------------------------------------------------------------
// tb_alu_control
// Self-checking bench for alu_control. A behavioural ALU stands in for the
// real one (driving noise on the flags it does not define); an integer
// reference model predicts every response.
// -----------------------------------------------------------------------------
module tb_alu_control;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_flag, in_acc, out_ready;
    logic         in_ready, out_valid;
    logic [3:0]   in_sel, alu_select;
    logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_res, out_result, acc;
    logic         alu_flagin, alu_neg, alu_zero, alu_cout, alu_ovf;
    logic         out_neg, out_zero, out_cout, out_ovf, out_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_acc  = 0;

    logic [2:0] noise = 3'd0;
    logic [W:0] wide;

    always #5 clk = ~clk;

    always @(negedge clk) noise <= 3'($urandom);

    alu_control #(.N(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_flag    (in_flag),
        .in_acc     (in_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_flagin (alu_flagin),
        .alu_select (alu_select),
        .alu_res    (alu_res),
        .alu_neg    (alu_neg),
        .alu_zero   (alu_zero),
        .alu_cout   (alu_cout),
        .alu_ovf    (alu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_err    (out_err),
        .acc        (acc)
    );

    // Stand-in ALU: flags it does not define for an opcode carry random noise.
    always_comb begin
        wide     = '0;
        alu_res  = '0;
        alu_neg  = noise[0];
        alu_zero = noise[1];
        alu_cout = noise[2];
        alu_ovf  = noise[0] ^ noise[1];
        case (alu_select)
            4'd0: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res = wide[W-1:0]; alu_cout = wide[W]; alu_zero = (wide[W-1:0] == '0);
            end
            4'd1: begin
                alu_res = alu_a - alu_b; alu_neg = alu_res[W-1]; alu_zero = (alu_res == '0);
            end
            4'd2: begin
                wide = {1'b0, alu_a} + 4'd1;
                alu_res = wide[W-1:0]; alu_cout = wide[W]; alu_zero = (wide[W-1:0] == '0);
            end
            4'd3: begin
                alu_res = alu_a - 3'd1; alu_neg = alu_res[W-1]; alu_zero = (alu_res == '0);
            end
            4'd4: alu_res = alu_a & alu_b;
            4'd5: alu_res = alu_a | alu_b;
            4'd6: alu_res = ~alu_a;
            4'd7: alu_res = alu_a ^ alu_b;
            4'd8: alu_res = alu_a << 1;
            4'd9: alu_res = alu_a >> 1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: what the response should be for an opcode on plain integers.
    task automatic ref_op(input int sel, input int a, input int b,
                          output int res, output int neg, output int zero,
                          output int cout, output int ovf);
        int s;
        s = 0; neg = 0; cout = 0;
        case (sel)
            0: begin s = a + b; cout = (s >= 8) ? 1 : 0; res = s % 8; end
            1: begin res = (a - b + 8) % 8; neg = (res >= 4) ? 1 : 0; end
            2: begin s = a + 1; cout = (s >= 8) ? 1 : 0; res = s % 8; end
            3: begin res = (a + 7) % 8; neg = (res >= 4) ? 1 : 0; end
            4: res = a & b;
            5: res = a | b;
            6: res = 7 - a;
            7: res = a ^ b;
            8: res = (a * 2) % 8;
            9: res = a / 2;
            default: res = 0;
        endcase
        ovf  = cout;
        zero = (res == 0) ? 1 : 0;
    endtask

    // Issue one request from IDLE and follow it through HOLD, keeping
    // out_ready low for `hold` cycles. Called and returns at a negedge.
    task automatic run_op(input int sel, input int a, input int b, input int fl,
                          input int use_acc, input int hold);
        int opa, er, en, ez, ec, eo, ee;
        check("in_ready_idle", in_ready, 1);
        opa = (use_acc != 0) ? exp_acc : a;
        in_valid = 1'b1; in_sel = 4'(sel); in_a = 3'(a); in_b = 3'(b);
        in_flag = 1'(fl); in_acc = 1'(use_acc); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_sel = 4'($urandom); in_a = 3'($urandom); in_b = 3'($urandom);
        in_acc = 1'($urandom);
        if (sel <= 9) begin
            check("issue_select", alu_select, sel);
            check("issue_a", alu_a, opa);
            check("issue_b", alu_b, b);
            check("issue_flagin", alu_flagin, fl);
            check("issue_out_valid", out_valid, 0);
            check("issue_in_ready", in_ready, 0);
            ref_op(sel, opa, b, er, en, ez, ec, eo);
            ee = 0;
            exp_acc = er;
            @(negedge clk);
        end else begin
            er = 0; en = 0; ez = 0; ec = 0; eo = 0; ee = 1;
        end
        for (int i = 0; i <= hold; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", out_result, er);
            check("hold_neg", out_neg, en);
            check("hold_zero", out_zero, ez);
            check("hold_cout", out_cout, ec);
            check("hold_ovf", out_ovf, eo);
            check("hold_err", out_err, ee);
            check("hold_acc", acc, exp_acc);
            if (i < hold) begin
                in_valid = 1'b1; in_sel = 4'($urandom); out_ready = 1'b0;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("done_in_ready", in_ready, 1);
        check("done_out_valid", out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sel;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0;
        in_flag = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_flags", {out_neg, out_zero, out_cout, out_ovf}, 0);
        check("rst_err", out_err, 0);
        check("rst_acc", acc, 0);
        check("rst_alu", {alu_a, alu_b, alu_flagin, alu_select}, 0);
        rst = 1'b0;
        exp_acc = 0;

        // Directed cases.
        run_op(0, 3, 2, 0, 0, 0);   // 3+2 = 5
        run_op(2, 0, 0, 1, 1, 0);   // inc acc: 6
        run_op(4, 0, 1, 0, 1, 1);   // acc & 1 = 0, zero
        run_op(0, 5, 4, 0, 0, 0);   // overflow: 1, cout/ovf
        run_op(1, 2, 3, 0, 0, 2);   // 2-3 = 7, neg
        run_op(12, 6, 6, 0, 0, 5);  // invalid, held off 5 cycles

        // Reset during ISSUE abandons the operation.
        in_valid = 1'b1; in_sel = 4'd1; in_a = 3'd6; in_b = 3'd1; in_acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_issue", alu_select, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_acc", acc, 0);
        check("midrst_select", alu_select, 0);
        exp_acc = 0;
        @(negedge clk);
        check("midrst_stay_idle", out_valid, 0);
        run_op(0, 1, 1, 0, 0, 0);   // 1+1 = 2

        // Randomised traffic.
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 4) == 0) sel = int'($urandom_range(10, 15));
            else                           sel = int'($urandom_range(0, 9));
            run_op(sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control.md
# alu_control

Sequencing front-end for the combinational ALU. It accepts one operation request at a time over a valid/ready handshake and drives registered operands and `select` into the ALU. It captures `resultado` and the four flags one cycle later, normalises the flags per opcode, and returns the result over a second valid/ready handshake. An internal accumulator holds the last good result so chained operations can reuse it as operand A.

## Interface
- `N`, 3: datapath width; must match the ALU width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: controller can accept; high only in IDLE.
- `in_sel` in 4: ALU opcode.
- `in_a`, `in_b` in N: operands.
- `in_flag` in 1: forwarded to ALU `flagin`.
- `in_acc` in 1: when 1, accumulator replaces `in_a`.
- `alu_a`, `alu_b` out N: registered ALU operands.
- `alu_flagin` out 1: registered.
- `alu_select` out 4: registered.
- `alu_res` in N: ALU `resultado`.
- `alu_neg`, `alu_zero`, `alu_cout`, `alu_ovf` in 1 each: ALU flags.
- `out_valid` out 1: response valid.
- `out_ready` in 1: consumer accepts the response.
- `out_result` out N: captured result.
- `out_neg`, `out_zero`, `out_cout`, `out_ovf` out 1 each: normalised flags.
- `out_err` out 1: request had an unsupported opcode.
- `acc` out N: accumulator value.

## Operation
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` with `in_sel` ≤ 9: register `alu_a` (= `acc` if `in_acc`, else `in_a`), `alu_b`, `alu_flagin`, `alu_select`, then go to ISSUE.
  - On `in_valid` with `in_sel` ≥ 10: load `out_result`=0, all flags 0, `out_err`=1, then go to HOLD. The ALU is not issued and `acc` is unchanged.
- ISSUE lasts one cycle. At its closing edge the controller captures `alu_res` into `out_result` and `acc`, sets `out_err`=0, and goes to HOLD. Flag normalisation by `alu_select`:
  - 0 (add), 2 (inc): neg=0; cout=ovf=`alu_cout`; zero=`alu_zero`.
  - 1 (sub), 3 (dec): neg=`alu_neg`; cout=ovf=0; zero=`alu_zero`. The ALU does not drive cout/ovf for these opcodes, so they are forced.
  - 4–9 (and, or, not, xor, shl, shr): neg=cout=ovf=0; zero=(`alu_res`==0), computed locally.
- HOLD:
  - `out_valid`=1; all `out_*` stay stable.
  - On `out_ready`=1, go to IDLE. The handshake completes on that edge.
- `alu_*` outputs hold their last value outside ISSUE.
- `out_*` hold their last value after the handshake; they are meaningful only while `out_valid`=1.
- Widths: all data N bits. The ALU wraps modulo 2^N; the controller performs no extension.

## Timing
- Reset (edge with `rst`=1):
  - state IDLE.
  - `in_ready`=1 after reset.
  - `out_valid`=0, `out_result`=0, all `out_*` flags 0, `out_err`=0.
  - `acc`=0.
  - `alu_a`=`alu_b`=0, `alu_flagin`=0, `alu_select`=0.
- Reset has priority over every transition. Reset in ISSUE or HOLD abandons the operation: no `out_valid`, and `acc` returns to 0.
- Request accepted at edge T (IDLE, `in_valid`):
  - `alu_*` valid in cycle T+1.
  - `out_valid`=1 in cycle T+2 for a valid opcode.
  - `out_valid`=1 in cycle T+1 for an invalid opcode.
- Minimum spacing between accepts is 3 cycles (valid opcode) or 2 cycles (invalid opcode) with `out_ready` tied high.
- `in_ready` is combinational from state only. No combinational path exists from `in_valid` or `out_ready` to any output.
- `out_ready` held low keeps HOLD indefinitely; `in_valid` is ignored meanwhile.
- `in_acc` uses the `acc` value present at the accept edge.

## Structure
- Shared package/header `alu_defs` contains:
  - opcode constants OP_SUMA=0, OP_RESTA=1, OP_INC=2, OP_DEC=3, OP_AND=4, OP_OR=5, OP_NOT=6, OP_XOR=7, OP_SHL=8, OP_SHR=9, OP_MAX_VALID=9;
  - state encodings ST_IDLE, ST_ISSUE, ST_HOLD;
  - default N.
- One combinational sub-module, `alu_flag_norm`: inputs select, `alu_res`, and the raw flags; outputs the normalised flags. The FSM, operand registers, and accumulator stay in the top module.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Add with backpressure off: accept `in_sel`=0, a=3, b=2 at T. Expect `alu_select`=0 at T+1, then at T+2 `out_result`=5, cout=0, zero=0, `out_valid`=1, and `acc`=5.
- Add overflow: a=5, b=4, sel 0 → result=1, cout=ovf=1, neg=0.
- Sub negative: a=2, b=3, sel 1 → result=7, neg=1, cout=ovf=0, zero=0.
- Accumulator chain: after the first test (`acc`=5), request sel 2, `in_acc`=1, `in_flag`=1 → `alu_a`=5, result=6, `acc`=6. Then sel 4 with `in_acc`=1, b=1 → result=0, zero=1.
- Invalid opcode and backpressure: sel 12 accepted at T → `out_valid` at T+1, `out_err`=1, result 0, `acc` unchanged. Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → outputs stable, `in_ready`=0. Raise `out_ready` → IDLE next cycle.
- Reset mid-operation: assert `rst` in the ISSUE cycle → next cycle IDLE, `out_valid`=0, `acc`=0, `alu_select`=0. Then a new add 1+1 completes normally with result 2.
